mem_stage_hs: RTL and testbench

Parametrised pipeline memory stage sitting between the execute and write-back stages. Replaces the fixed single-cycle memory access with a valid/ready request and response handshake to a data memory of variable latency. Performs store lane steering and byte-enable generation, and load extraction with sign or zero extension. Stalls execute while an access is outstanding and registers all write-back fields with an explicit valid bit.

---
 rtl/mem_stage_hs_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/mem_stage_hs.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_hs_pkg.sv
// Shared types for the memory stage: state encoding, load/store funct3
// codes, default-width data aliases and the natural-alignment helper.
package mem_stage_hs_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef logic [XLEN_DEF-1:0] data_t;
  typedef logic [XLEN_DEF-1:0] addr_t;

  typedef logic [1:0] mem_state_e;
  localparam mem_state_e S_IDLE = 2'd0;
  localparam mem_state_e S_REQ  = 2'd1;
  localparam mem_state_e S_RSP  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    logic [3:0] lsb_mask;
    lsb_mask = (4'd1 << funct3[1:0]) - 4'd1;
    return (off & lsb_mask[2:0]) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and data shift, load
// right-shift and sign/zero extension. Bytes past the word edge are dropped.
module mem_lane_align
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BE_W = XLEN / 8
) (
  input  logic [2:0]              funct3_i,
  input  logic [$clog2(BE_W)-1:0] off_i,
  input  logic [XLEN-1:0]         wdata_i,
  input  logic [XLEN-1:0]         rdata_i,
  output logic [BE_W-1:0]         be_o,
  output logic [XLEN-1:0]         wdata_o,
  output logic [XLEN-1:0]         rdata_o
);

  logic [BE_W-1:0] mask;
  logic [XLEN-1:0] sh;

  // Store: size mask shifted to the lane, data shifted by whole bytes.
  always_comb begin
    mask = '0;
    case (funct3_i[1:0])
      2'b00:   mask = BE_W'(1);
      2'b01:   mask = BE_W'(3);
      2'b10:   mask = BE_W'(4'hF);
      default: mask = (XLEN == 64) ? BE_W'(8'hFF) : '0;
    endcase
    be_o    = mask << off_i;
    wdata_o = wdata_i << {off_i, 3'b000};
  end

  // Load: bring the addressed byte to bit 0, then extend by funct3.
  always_comb begin
    sh      = rdata_i >> {off_i, 3'b000};
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = XLEN'($signed(sh[7:0]));
      F3_H:    rdata_o = XLEN'($signed(sh[15:0]));
      F3_W:    rdata_o = XLEN'($signed(sh[31:0]));
      F3_BU:   rdata_o = XLEN'(sh[7:0]);
      F3_HU:   rdata_o = XLEN'(sh[15:0]);
      F3_WU:   rdata_o = (XLEN == 64) ? XLEN'(sh[31:0]) : '0;
      F3_D:    rdata_o = (XLEN == 64) ? sh : '0;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage with valid/ready request and response handshake.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned BE_W       = XLEN / 8  // derived from XLEN; leave at default
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_write_data,
  input  logic [2:0]            ex_funct3,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [1:0]            ex_result_src,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_pc_plus4,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [XLEN-1:0]       mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [BE_W-1:0]       mem_req_be,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_result_src,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_read_data,
  output logic [XLEN-1:0]       wb_pc_plus4
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap,
  output logic [XLEN-1:0]       misalign_addr
`endif
);

  localparam int unsigned OFFW = $clog2(BE_W);

  mem_state_e state_q, state_d;

  logic [XLEN-1:0]       h_addr_q, h_wdata_q, h_pc4_q;
  logic [2:0]            h_funct3_q;
  logic                  h_we_q, h_reg_write_q;
  logic [1:0]            h_result_src_q;
  logic [REG_ADDR_W-1:0] h_rd_q;

  logic                  wb_valid_q, wb_reg_write_q;
  logic [1:0]            wb_result_src_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [XLEN-1:0]       wb_alu_result_q, wb_read_data_q, wb_pc_plus4_q;

  logic            accept, ex_mem, misal;
  logic [BE_W-1:0] lane_be;
  logic [XLEN-1:0] lane_wdata, lane_rdata;

  assign ex_ready = (state_q == S_IDLE);
  assign accept   = ex_valid && ex_ready;
  assign ex_mem   = ex_mem_read || ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = ex_mem && is_misaligned(ex_funct3, 3'(ex_alu_result[OFFW-1:0]));
`else
  assign misal = 1'b0;
`endif

  mem_lane_align #(
    .XLEN (XLEN),
    .BE_W (BE_W)
  ) u_lane (
    .funct3_i (h_funct3_q),
    .off_i    (h_addr_q[OFFW-1:0]),
    .wdata_i  (h_wdata_q),
    .rdata_i  (mem_rsp_rdata),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  // Request fields come only from the holding register, so they stay stable in REQ.
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = h_we_q;
  assign mem_req_addr  = {h_addr_q[XLEN-1:OFFW], OFFW'(0)};
  assign mem_req_wdata = lane_wdata;
  assign mem_req_be    = h_we_q ? lane_be : '0;

  // Next-state: memory ops go through REQ; loads additionally wait in RSP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && ex_mem && !misal) state_d = S_REQ;
      S_REQ:   if (mem_req_ready) state_d = h_we_q ? S_IDLE : S_RSP;
      S_RSP:   if (mem_rsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Holding register: captures the accepted instruction; a set write flag wins over read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_addr_q       <= '0;
      h_wdata_q      <= '0;
      h_pc4_q        <= '0;
      h_funct3_q     <= '0;
      h_we_q         <= 1'b0;
      h_reg_write_q  <= 1'b0;
      h_result_src_q <= '0;
      h_rd_q         <= '0;
    end else if (accept) begin
      h_addr_q       <= ex_alu_result;
      h_wdata_q      <= ex_write_data;
      h_pc4_q        <= ex_pc_plus4;
      h_funct3_q     <= ex_funct3;
      h_we_q         <= ex_mem_write;
      h_reg_write_q  <= ex_reg_write;
      h_result_src_q <= ex_result_src;
      h_rd_q         <= ex_rd;
    end
  end

  // Write-back register: valid and reg_write pulse for one cycle, other fields hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= '0;
      wb_rd_q         <= '0;
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_pc_plus4_q   <= '0;
    end else begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      if (accept && (!ex_mem || misal)) begin
        wb_valid_q      <= 1'b1;
        wb_reg_write_q  <= ex_reg_write && !misal;
        wb_result_src_q <= ex_result_src;
        wb_rd_q         <= ex_rd;
        wb_alu_result_q <= ex_alu_result;
        wb_pc_plus4_q   <= ex_pc_plus4;
      end else if ((state_q == S_REQ && mem_req_ready && h_we_q) ||
                   (state_q == S_RSP && mem_rsp_valid)) begin
        wb_valid_q      <= 1'b1;
        wb_reg_write_q  <= h_reg_write_q;
        wb_result_src_q <= h_result_src_q;
        wb_rd_q         <= h_rd_q;
        wb_alu_result_q <= h_addr_q;
        wb_pc_plus4_q   <= h_pc4_q;
        if (state_q == S_RSP) wb_read_data_q <= lane_rdata;
      end
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_result_src = wb_result_src_q;
  assign wb_rd         = wb_rd_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_pc_plus4   = wb_pc_plus4_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic            trap_q;
  logic [XLEN-1:0] trap_addr_q;

  // Trap flag pulses with the write-back of a misaligned access; address holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q <= accept && misal;
      if (accept && misal) trap_addr_q <= ex_alu_result;
    end
  end

  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a 32-bit instance for the main sequences
// and a 64-bit instance for doubleword and word-extension loads.
module tb_mem_stage_hs;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_alu_result, ex_write_data, ex_pc_plus4;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_result_src;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]  mem_req_be;
  logic        wb_valid, wb_reg_write;
  logic [1:0]  wb_result_src;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus4;

  // 64-bit instance signals
  logic        w_ex_valid, w_ex_ready, w_ex_mem_read, w_ex_mem_write, w_ex_reg_write;
  logic [63:0] w_ex_alu_result, w_ex_write_data, w_ex_pc_plus4;
  logic [2:0]  w_ex_funct3;
  logic [1:0]  w_ex_result_src;
  logic [4:0]  w_ex_rd;
  logic        w_mem_req_valid, w_mem_req_ready, w_mem_req_we, w_mem_rsp_valid;
  logic [63:0] w_mem_req_addr, w_mem_req_wdata, w_mem_rsp_rdata;
  logic [7:0]  w_mem_req_be;
  logic        w_wb_valid, w_wb_reg_write;
  logic [1:0]  w_wb_result_src;
  logic [4:0]  w_wb_rd;
  logic [63:0] w_wb_alu_result, w_wb_read_data, w_wb_pc_plus4;

`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap, w_misalign_trap;
  logic [31:0] misalign_addr;
  logic [63:0] w_misalign_addr;
`endif

  mem_stage_hs u_dut32 (
    .clk(clk), .reset(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
    .ex_rd(ex_rd), .ex_pc_plus4(ex_pc_plus4),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus4(wb_pc_plus4)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
`endif
  );

  mem_stage_hs #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(rst_n),
    .ex_valid(w_ex_valid), .ex_ready(w_ex_ready), .ex_alu_result(w_ex_alu_result),
    .ex_write_data(w_ex_write_data), .ex_funct3(w_ex_funct3), .ex_mem_read(w_ex_mem_read),
    .ex_mem_write(w_ex_mem_write), .ex_reg_write(w_ex_reg_write), .ex_result_src(w_ex_result_src),
    .ex_rd(w_ex_rd), .ex_pc_plus4(w_ex_pc_plus4),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_req_we(w_mem_req_we),
    .mem_req_addr(w_mem_req_addr), .mem_req_wdata(w_mem_req_wdata), .mem_req_be(w_mem_req_be),
    .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_rdata(w_mem_rsp_rdata),
    .wb_valid(w_wb_valid), .wb_reg_write(w_wb_reg_write), .wb_result_src(w_wb_result_src),
    .wb_rd(w_wb_rd), .wb_alu_result(w_wb_alu_result), .wb_read_data(w_wb_read_data),
    .wb_pc_plus4(w_wb_pc_plus4)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(w_misalign_trap), .misalign_addr(w_misalign_addr)
`endif
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                       input logic [1:0] src);
    ex_valid      = 1'b1;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_funct3     = f3;
    ex_alu_result = addr;
    ex_write_data = data;
    ex_rd         = rd;
    ex_result_src = src;
    ex_pc_plus4   = addr + 32'h4000;
  endtask

  task automatic alu_op(input string tag, input logic [31:0] res, input logic [4:0] rd);
    drive(1'b0, 1'b0, 1'b1, 3'b000, res, 32'h0, rd, 2'd0);
    check({tag, ".ex_ready"}, 64'(ex_ready), 64'd1);
    tick();
    ex_valid = 1'b0;
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".wb_alu"}, 64'(wb_alu_result), 64'(res));
    check({tag, ".wb_rd"}, 64'(wb_rd), 64'(rd));
    check({tag, ".wb_rw"}, 64'(wb_reg_write), 64'd1);
    check({tag, ".wb_pc4"}, 64'(wb_pc_plus4), 64'(res + 32'h4000));
    check({tag, ".ready_kept"}, 64'(ex_ready), 64'd1);
    check({tag, ".no_req"}, 64'(mem_req_valid), 64'd0);
    tick();
    check({tag, ".wb_pulse"}, 64'(wb_valid), 64'd0);
    check({tag, ".rw_low"}, 64'(wb_reg_write), 64'd0);
    check({tag, ".alu_hold"}, 64'(wb_alu_result), 64'(res));
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic both, input int unsigned delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    drive(both, 1'b1, 1'b0, f3, addr, data, 5'd0, 2'd0);
    check({tag, ".ex_ready"}, 64'(ex_ready), 64'd1);
    tick();
    ex_valid = 1'b0;
    for (int unsigned i = 0; i <= delay; i++) begin
      check({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, ".we"}, 64'(mem_req_we), 64'd1);
      check({tag, ".addr"}, 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
      check({tag, ".be"}, 64'(mem_req_be), 64'(exp_be));
      check({tag, ".wdata"}, 64'(mem_req_wdata), 64'(exp_wd));
      check({tag, ".stall"}, 64'(ex_ready), 64'd0);
      check({tag, ".no_wb"}, 64'(wb_valid), 64'd0);
      if (i == delay) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".wb_rw"}, 64'(wb_reg_write), 64'd0);
    check({tag, ".wb_alu"}, 64'(wb_alu_result), 64'(addr));
    check({tag, ".req_done"}, 64'(mem_req_valid), 64'd0);
    check({tag, ".ready_back"}, 64'(ex_ready), 64'd1);
    tick();
    check({tag, ".wb_pulse"}, 64'(wb_valid), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int unsigned gap, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b1, f3, addr, 32'h0, 5'd7, 2'd1);
    tick();
    ex_valid = 1'b0;
    check({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, ".we"}, 64'(mem_req_we), 64'd0);
    check({tag, ".be"}, 64'(mem_req_be), 64'd0);
    check({tag, ".addr"}, 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
    check({tag, ".stall"}, 64'(ex_ready), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int unsigned i = 0; i < gap; i++) begin
      check({tag, ".wait_wb"}, 64'(wb_valid), 64'd0);
      check({tag, ".wait_req"}, 64'(mem_req_valid), 64'd0);
      check({tag, ".wait_stall"}, 64'(ex_ready), 64'd0);
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".rdata"}, 64'(wb_read_data), 64'(exp));
    check({tag, ".wb_rw"}, 64'(wb_reg_write), 64'd1);
    check({tag, ".wb_rd"}, 64'(wb_rd), 64'd7);
    check({tag, ".wb_src"}, 64'(wb_result_src), 64'd1);
    check({tag, ".ready_back"}, 64'(ex_ready), 64'd1);
    tick();
    check({tag, ".wb_pulse"}, 64'(wb_valid), 64'd0);
    check({tag, ".rdata_hold"}, 64'(wb_read_data), 64'(exp));
  endtask

  task automatic ld64(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] rdata, input logic [63:0] exp);
    w_ex_valid      = 1'b1;
    w_ex_mem_read   = 1'b1;
    w_ex_reg_write  = 1'b1;
    w_ex_funct3     = f3;
    w_ex_alu_result = addr;
    w_ex_rd         = 5'd9;
    w_ex_result_src = 2'd1;
    w_ex_pc_plus4   = addr + 64'h4;
    tick();
    w_ex_valid = 1'b0;
    check({tag, ".req_valid"}, 64'(w_mem_req_valid), 64'd1);
    check({tag, ".we"}, 64'(w_mem_req_we), 64'd0);
    check({tag, ".be"}, 64'(w_mem_req_be), 64'd0);
    check({tag, ".addr"}, w_mem_req_addr, addr & 64'hFFFF_FFFF_FFFF_FFF8);
    check({tag, ".wdata"}, w_mem_req_wdata, 64'd0);
    check({tag, ".stall"}, 64'(w_ex_ready), 64'd0);
    w_mem_req_ready = 1'b1;
    tick();
    w_mem_req_ready = 1'b0;
    w_mem_rsp_valid = 1'b1;
    w_mem_rsp_rdata = rdata;
    tick();
    w_mem_rsp_valid = 1'b0;
    check({tag, ".wb_valid"}, 64'(w_wb_valid), 64'd1);
    check({tag, ".rdata"}, w_wb_read_data, exp);
    check({tag, ".wb_rw"}, 64'(w_wb_reg_write), 64'd1);
    check({tag, ".wb_rd"}, 64'(w_wb_rd), 64'd9);
    check({tag, ".wb_src"}, 64'(w_wb_result_src), 64'd1);
    check({tag, ".wb_alu"}, w_wb_alu_result, addr);
    check({tag, ".wb_pc4"}, w_wb_pc_plus4, addr + 64'h4);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_alu_result = '0; ex_write_data = '0; ex_pc_plus4 = '0; ex_funct3 = '0;
    ex_result_src = '0; ex_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    w_ex_valid = 1'b0; w_ex_mem_read = 1'b0; w_ex_mem_write = 1'b0; w_ex_reg_write = 1'b0;
    w_ex_alu_result = '0; w_ex_write_data = '0; w_ex_pc_plus4 = '0; w_ex_funct3 = '0;
    w_ex_result_src = '0; w_ex_rd = '0;
    w_mem_req_ready = 1'b0; w_mem_rsp_valid = 1'b0; w_mem_rsp_rdata = '0;

    tick();
    tick();
    check("rst.ex_ready", 64'(ex_ready), 64'd1);
    check("rst.wb_valid", 64'(wb_valid), 64'd0);
    check("rst.req_valid", 64'(mem_req_valid), 64'd0);
    check("rst.wb_alu", 64'(wb_alu_result), 64'd0);
    check("rst.wb_rdata", 64'(wb_read_data), 64'd0);
    check("rst64.ex_ready", 64'(w_ex_ready), 64'd1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("rst.trap", 64'(misalign_trap), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    alu_op("alu", 32'h1234, 5'd5);

    do_store("sb",   3'b000, 32'h103, 32'h0000_00AB, 1'b0, 3, 4'h8, 32'hAB00_0000);
    do_store("sh_rw", 3'b001, 32'h102, 32'h0000_BEEF, 1'b1, 0, 4'hC, 32'hBEEF_0000);
    do_store("sw",   3'b010, 32'h100, 32'h1122_3344, 1'b0, 1, 4'hF, 32'h1122_3344);

    do_load("lh",  3'b001, 32'h102, 32'h8001_0000, 1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 1, 32'h0000_8001);
    do_load("lb",  3'b000, 32'h103, 32'h9A00_0000, 0, 32'hFFFF_FF9A);
    do_load("lbu", 3'b100, 32'h101, 32'h0000_C500, 2, 32'h0000_00C5);
    do_load("lw",  3'b010, 32'h104, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    do_load("f3_111", 3'b111, 32'h100, 32'hFFFF_FFFF, 0, 32'h0);

`ifndef MEM_MISALIGN_TRAP_EN
    do_load("lw_mis", 3'b010, 32'h101, 32'hDEAD_BEEF, 0, 32'h00DE_ADBE);
    do_store("sw_mis", 3'b010, 32'h102, 32'h1122_3344, 1'b0, 0, 4'hC, 32'h3344_0000);
`endif

    // Reset while a load waits in RSP
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd4, 2'd1);
    tick();
    ex_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rsp_rst.in_rsp", 64'(ex_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rsp_rst.async_ready", 64'(ex_ready), 64'd1);
    check("rsp_rst.async_req", 64'(mem_req_valid), 64'd0);
    tick();
    check("rsp_rst.wb_valid", 64'(wb_valid), 64'd0);
    check("rsp_rst.wb_rdata", 64'(wb_read_data), 64'd0);
    check("rsp_rst.wb_rd", 64'(wb_rd), 64'd0);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    check("rsp_rst.ignored", 64'(wb_valid), 64'd0);
    check("rsp_rst.rdata0", 64'(wb_read_data), 64'd0);
    alu_op("after_rst", 32'h77, 5'd3);

`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 5'd9, 2'd1);
    tick();
    ex_valid = 1'b0;
    check("trap.no_req", 64'(mem_req_valid), 64'd0);
    check("trap.wb_valid", 64'(wb_valid), 64'd1);
    check("trap.flag", 64'(misalign_trap), 64'd1);
    check("trap.addr", 64'(misalign_addr), 64'h101);
    check("trap.wb_rw", 64'(wb_reg_write), 64'd0);
    check("trap.ready", 64'(ex_ready), 64'd1);
    tick();
    check("trap.pulse", 64'(misalign_trap), 64'd0);
    check("trap.addr_hold", 64'(misalign_addr), 64'h101);
    check("trap64.flag", 64'(w_misalign_trap), 64'd0);
    check("trap64.addr", w_misalign_addr, 64'd0);
`endif

    ld64("ld64",  3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    ld64("lw64",  3'b010, 64'h4, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000);
    ld64("lwu64", 3'b110, 64'h4, 64'h8000_0000_1234_5678, 64'h0000_0000_8000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
